// File: rtl/mem_write_checker.sv
// Bus-snooping pass/fail monitor: records the last write to each check address and
// reports a verdict on timeout or, optionally, as soon as every enabled slot matches.
module mem_write_checker #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_CHECKS = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned EARLY_EXIT = 1,
    localparam int unsigned IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                         ph2,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CNT_W-1:0]             timeout,
    input  logic [NUM_CHECKS*ADDR_W-1:0] chk_addr,
    input  logic [NUM_CHECKS*DATA_W-1:0] chk_data,
    input  logic [NUM_CHECKS-1:0]        chk_en,
    input  logic [ADDR_W-1:0]            bus_addr,
    input  logic [DATA_W-1:0]            bus_data,
    input  logic                         bus_we,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic [IDX_W-1:0]             fail_idx,
    output logic [DATA_W-1:0]            fail_val,
    output logic [NUM_CHECKS-1:0]        seen,
    output logic [CNT_W-1:0]             cycle_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                               r_state, w_state_next;
    logic [NUM_CHECKS-1:0][DATA_W-1:0]    r_last, w_last_next;
    logic [NUM_CHECKS-1:0]                r_seen, w_seen_next;
    logic [CNT_W-1:0]                     r_cnt;
    logic                                 r_pass;
    logic [NUM_CHECKS-1:0]                w_match_q, w_match_d;
    logic                                 w_allmatch_q, w_allmatch_d;
    logic [CNT_W-1:0]                     w_eff_to;
    logic [CNT_W:0]                       w_cnt_inc;
    logic                                 w_last_cycle, w_exit, w_run;
    logic [IDX_W-1:0]                     w_fail_idx;
    logic [DATA_W-1:0]                    w_fail_val;
    logic                                 w_found;

    assign w_run = (r_state == StRun);

    // Start clears the record before any write in the same cycle can land.
    always_comb begin
        w_last_next = r_last;
        w_seen_next = r_seen;
        if (start) begin
            w_last_next = '0;
            w_seen_next = '0;
        end else if (w_run && bus_we) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (bus_addr == chk_addr[i*ADDR_W +: ADDR_W]) begin
                    w_last_next[i] = bus_data;
                    w_seen_next[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_match_q = '0;
        w_match_d = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            w_match_q[i] = ~chk_en[i] |
                           (r_seen[i] & (r_last[i] == chk_data[i*DATA_W +: DATA_W]));
            w_match_d[i] = ~chk_en[i] |
                           (w_seen_next[i] & (w_last_next[i] == chk_data[i*DATA_W +: DATA_W]));
        end
    end

    assign w_allmatch_q = &w_match_q;
    assign w_allmatch_d = &w_match_d;
    assign w_eff_to     = (timeout == '0) ? CNT_W'(1) : timeout;
    assign w_cnt_inc    = {1'b0, r_cnt} + (CNT_W+1)'(1);
    // >= rather than == so an illegal mid-run timeout change cannot strand the FSM in RUN.
    assign w_last_cycle = (w_cnt_inc >= {1'b0, w_eff_to});
    assign w_exit       = w_last_cycle | ((EARLY_EXIT != 0) & w_allmatch_q);

    always_ff @(posedge ph2 or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StRun;
            StRun:   if (!start && w_exit) w_state_next = StDone;
            StDone:  if (start) w_state_next = StRun;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge ph2 or negedge reset) begin
        if (!reset) begin
            r_last <= '0;
            r_seen <= '0;
            r_cnt  <= '0;
            r_pass <= 1'b0;
        end else begin
            r_last <= w_last_next;
            r_seen <= w_seen_next;
            if (start) begin
                r_cnt  <= '0;
                r_pass <= 1'b0;
            end else if (w_run) begin
                if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
                if (w_exit) r_pass <= w_allmatch_d;
            end
        end
    end

    always_comb begin
        w_fail_idx = '0;
        w_fail_val = '0;
        w_found    = 1'b0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (!w_match_q[i] && !w_found) begin
                w_found    = 1'b1;
                w_fail_idx = IDX_W'(i);
                w_fail_val = r_last[i];
            end
        end
    end

    always_comb begin
        busy      = (r_state == StRun);
        done      = (r_state == StDone);
        pass      = done & r_pass;
        fail      = done & ~r_pass;
        fail_idx  = done ? w_fail_idx : '0;
        fail_val  = done ? w_fail_val : '0;
        seen      = r_seen;
        cycle_cnt = r_cnt;
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench: two checkers (early exit on / off) share one bus; a list-based
// model predicts each run's verdict and a monitor compares on every rising done.
module tb_mem_write_checker;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int NC   = 4;
    localparam int CW   = 16;
    localparam int MAXC = 400;

    logic             ph2 = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CW-1:0]    timeout = '0;
    logic [NC*AW-1:0] chk_addr = '0;
    logic [NC*DW-1:0] chk_data = '0;
    logic [NC-1:0]    chk_en = '0;
    logic [AW-1:0]    bus_addr = '0;
    logic [DW-1:0]    bus_data = '0;
    logic             bus_we = 1'b0;

    logic          busy [2];
    logic          done [2];
    logic          pass_o [2];
    logic          fail_o [2];
    logic [1:0]    fidx [2];
    logic [DW-1:0] fval [2];
    logic [NC-1:0] seen_o [2];
    logic [CW-1:0] cnt_o [2];

    always #5 ph2 = ~ph2;

    mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NC), .CNT_W(CW),
                        .EARLY_EXIT(1)) u_dut_ee (
        .ph2(ph2), .reset(rst_n), .start(start), .timeout(timeout),
        .chk_addr(chk_addr), .chk_data(chk_data), .chk_en(chk_en),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we),
        .busy(busy[0]), .done(done[0]), .pass(pass_o[0]), .fail(fail_o[0]),
        .fail_idx(fidx[0]), .fail_val(fval[0]), .seen(seen_o[0]), .cycle_cnt(cnt_o[0])
    );

    mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NC), .CNT_W(CW),
                        .EARLY_EXIT(0)) u_dut_to (
        .ph2(ph2), .reset(rst_n), .start(start), .timeout(timeout),
        .chk_addr(chk_addr), .chk_data(chk_data), .chk_en(chk_en),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we),
        .busy(busy[1]), .done(done[1]), .pass(pass_o[1]), .fail(fail_o[1]),
        .fail_idx(fidx[1]), .fail_val(fval[1]), .seen(seen_o[1]), .cycle_cnt(cnt_o[1])
    );

    typedef struct packed {
        logic          pass;
        logic [1:0]    idx;
        logic [DW-1:0] val;
        logic [NC-1:0] seen;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q [2][$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Write schedule, indexed by RUN cycle (0 = first cycle after start).
    bit            s_we   [MAXC];
    logic [AW-1:0] s_addr [MAXC];
    logic [DW-1:0] s_data [MAXC];

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    function automatic bit slot_ok(input int i, input logic [DW-1:0] l, input bit s);
        return !chk_en[i] || (s && l == chk_data[i*DW +: DW]);
    endfunction

    // Replays the schedule as a list of writes; stops on timeout or (ee) when every
    // enabled slot already matched at the start of a cycle.
    function automatic exp_t model(input bit ee);
        logic [DW-1:0] last [NC];
        logic [NC-1:0] sn;
        int            eff, kend;
        bit            stop, all;
        exp_t          e;
        eff  = (timeout == 0) ? 1 : int'(timeout);
        sn   = '0;
        stop = 0;
        kend = 0;
        for (int i = 0; i < NC; i++) last[i] = '0;
        for (int k = 0; k < eff && !stop; k++) begin
            all = 1;
            for (int i = 0; i < NC; i++) if (!slot_ok(i, last[i], sn[i])) all = 0;
            if (ee && all) stop = 1;
            if (s_we[k]) begin
                for (int i = 0; i < NC; i++) begin
                    if (s_addr[k] == chk_addr[i*AW +: AW]) begin
                        last[i] = s_data[k];
                        sn[i]   = 1'b1;
                    end
                end
            end
            kend = k;
        end
        e.cnt  = CW'(kend + 1);
        e.seen = sn;
        e.pass = 1'b1;
        e.idx  = '0;
        e.val  = '0;
        for (int i = NC - 1; i >= 0; i--) begin
            if (!slot_ok(i, last[i], sn[i])) begin
                e.pass = 1'b0;
                e.idx  = 2'(i);
                e.val  = last[i];
            end
        end
        return e;
    endfunction

    // Monitor: compare each completed run against the oldest expectation.
    logic prev_done [2];
    always @(negedge ph2) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (done[d] && !prev_done[d]) begin
                if (exp_q[d].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done dut%0d: got done=1 expected no run pending", d);
                end else begin
                    e = exp_q[d].pop_front();
                    check("pass", d, 32'(pass_o[d]), 32'(e.pass));
                    check("fail", d, 32'(fail_o[d]), 32'(!e.pass));
                    check("fail_idx", d, 32'(fidx[d]), 32'(e.idx));
                    check("fail_val", d, 32'(fval[d]), 32'(e.val));
                    check("seen", d, 32'(seen_o[d]), 32'(e.seen));
                    check("cycle_cnt", d, 32'(cnt_o[d]), 32'(e.cnt));
                    check("busy_in_done", d, 32'(busy[d]), 32'd0);
                end
            end
            prev_done[d] <= done[d];
        end
    end

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] v);
        chk_addr[i*AW +: AW] = a;
        chk_data[i*DW +: DW] = v;
    endtask

    task automatic default_slots();
        for (int i = 0; i < NC; i++) set_slot(i, AW'(16'h0F0 + i), '0);
        chk_en = '0;
    endtask

    task automatic clear_sched();
        for (int k = 0; k < MAXC; k++) begin
            s_we[k]   = 0;
            s_addr[k] = '0;
            s_data[k] = '0;
        end
    endtask

    task automatic rand_sched(input int prob);
        for (int k = 0; k < MAXC; k++) begin
            s_we[k]   = ($urandom % 100) < prob;
            s_addr[k] = AW'(16'h10 * (1 + $urandom % 5));
            s_data[k] = DW'($urandom % 4);
        end
    endtask

    task automatic put_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] v);
        s_we[k]   = 1;
        s_addr[k] = a;
        s_data[k] = v;
    endtask

    task automatic pulse_start(input bit wr_with_start);
        @(posedge ph2);
        #1;
        start = 1'b1;
        if (wr_with_start) begin
            bus_we   = 1'b1;
            bus_addr = chk_addr[AW-1:0];
            bus_data = chk_data[DW-1:0];
        end else begin
            bus_we = 1'b0;
        end
        @(posedge ph2);
        #1;
        start = 1'b0;
    endtask

    task automatic drive_cycle(input int c);
        bus_we   = s_we[c];
        bus_addr = s_addr[c];
        bus_data = s_data[c];
        @(posedge ph2);
        #1;
    endtask

    // Start a run that is abandoned (restart or reset) before it completes.
    task automatic drive_partial(input int n);
        pulse_start(0);
        for (int c = 0; c < n; c++) drive_cycle(c);
        bus_we = 1'b0;
    endtask

    task automatic run(input bit wr_with_start);
        int bound;
        exp_q[0].push_back(model(1));
        exp_q[1].push_back(model(0));
        pulse_start(wr_with_start);
        bound = ((timeout == 0) ? 1 : int'(timeout)) + 5;
        for (int c = 0; c < bound; c++) begin
            if (done[0] && done[1]) break;
            drive_cycle(c);
        end
        bus_we = 1'b0;
        if (!(done[0] && done[1])) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_timeout: got done=%0b%0b expected 11 within %0d cycles",
                     done[0], done[1], bound);
        end
        @(negedge ph2);
        @(negedge ph2);
        for (int d = 0; d < 2; d++) begin
            if (exp_q[d].size() != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_done dut%0d: got %0d pending expected 0", d,
                         exp_q[d].size());
                exp_q[d].delete();
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        for (int d = 0; d < 2; d++) begin
            check({name, "_flags"}, d,
                  32'({busy[d], done[d], pass_o[d], fail_o[d], fidx[d], seen_o[d]}), 32'd0);
            check({name, "_vals"}, d, 32'({fval[d], cnt_o[d]}), 32'd0);
        end
    endtask

    initial begin
        prev_done[0] = 1'b0;
        prev_done[1] = 1'b0;
        default_slots();
        clear_sched();
        repeat (3) @(posedge ph2);
        #1;
        check_idle_outputs("reset_state");
        rst_n = 1'b1;

        // Single slot, write at cycle 100, long timeout.
        set_slot(0, 16'h00A9, 8'hAA);
        chk_en  = 4'b0001;
        timeout = 350;
        put_write(99, 16'h00A9, 8'hAA);
        run(0);

        // Correct value later overwritten with a wrong one.
        put_write(150, 16'h00A9, 8'h55);
        run(0);

        // Two slots matched by cycle 40.
        default_slots();
        clear_sched();
        set_slot(0, 16'h0010, 8'h01);
        set_slot(1, 16'h0020, 8'h02);
        chk_en  = 4'b0011;
        timeout = 100;
        put_write(20, 16'h0010, 8'h01);
        put_write(39, 16'h0020, 8'h02);
        run(0);

        // Slot 2 never written.
        default_slots();
        clear_sched();
        set_slot(1, 16'h0020, 8'h07);
        set_slot(2, 16'h0030, 8'h09);
        chk_en  = 4'b0110;
        timeout = 20;
        put_write(5, 16'h0020, 8'h07);
        run(0);

        // Matching write coincides with start and must be dropped.
        default_slots();
        clear_sched();
        set_slot(0, 16'h0010, 8'h01);
        chk_en  = 4'b0001;
        timeout = 15;
        run(1);

        // No slots enabled; timeout 0 behaves as 1.
        default_slots();
        rand_sched(50);
        timeout = 30;
        run(0);
        chk_en  = 4'b1011;
        timeout = 0;
        run(0);

        // Two slots share one address and update together.
        default_slots();
        clear_sched();
        set_slot(0, 16'h0010, 8'h03);
        set_slot(2, 16'h0010, 8'h03);
        chk_en  = 4'b0101;
        timeout = 25;
        put_write(7, 16'h0010, 8'h03);
        run(0);

        // Restart while running.
        rand_sched(40);
        timeout = 40;
        drive_partial(6);
        run(0);

        // Asynchronous reset in the middle of a run.
        rand_sched(60);
        timeout = 50;
        drive_partial(8);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(posedge ph2);
        #1;
        rst_n = 1'b1;
        default_slots();
        clear_sched();
        set_slot(3, 16'h0040, 8'h02);
        chk_en  = 4'b1000;
        timeout = 30;
        put_write(3, 16'h0040, 8'h02);
        run(0);

        // Randomised runs over a small address/data pool so matches are common.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NC; i++)
                set_slot(i, AW'(16'h10 * (1 + $urandom % 4)), DW'($urandom % 4));
            chk_en  = NC'($urandom);
            timeout = CW'($urandom_range(0, 60));
            rand_sched(45);
            run(0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

endmodule
